// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, wait-state limit
// and byte-lane helpers.
package mem_pkg;

  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned WAIT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Pick one byte lane out of a stored word (lane 0 = bits [7:0]).
  function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Byte-write enables for a word or single-lane access.
  function automatic logic [3:0] lane_be(input logic byte_acc, input logic [1:0] lane);
    return byte_acc ? 4'(4'b0001 << lane) : 4'hF;
  endfunction

  // Write data aligned to the RAM lanes; a byte write replicates data[7:0]
  // so the enabled lane picks up the right value.
  function automatic logic [31:0] lane_merge(input logic byte_acc, input logic [31:0] data);
    return byte_acc ? {4{data[7:0]}} : data;
  endfunction

endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port word RAM with per-byte write enables.
// Ports: clk; we[3:0] byte enables; addr word index; wdata write word;
//        rdata combinational read of the addressed word.
// Contents are never reset.
module word_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-wise synchronous write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core bus: word-addressed RAM with byte lanes,
// little-endian storage, configurable wait states and a preload port.
// Ports: clk, n_reset (async active-low); address/data_in/memory_read/
//        memory_write/mem_byte request from core; data_out/mem_ready/mem_error
//        registered response; load_en/load_addr/load_data preload port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        mem_byte,
  output logic        mem_ready,
  output logic        mem_error,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Count value on the last ACCESS cycle; unused when WAIT_STATES is 0.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES - 1);

  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
    $error("mem_responder: WAIT_STATES exceeds MAX_WAIT_STATES");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mem_responder: BASE_ADDR must be 4-aligned");
  end

  // In-range test without wrap-around: below base or past the end both fail.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH_WORDS));
  endfunction

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       req_addr, req_data;
  logic              req_byte, req_read, req_write, req_err;

  logic              live_req, live_err, accept, commit;
  logic [31:0]       op_addr, op_data, op_off, load_off, rd_val;
  logic              op_byte, op_read, op_write, op_err;
  logic [3:0]        ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  // Request decode and RAM port mux: preload in IDLE, otherwise the access
  // that completes on this edge (live inputs when there are no wait states).
  always_comb begin
    live_req  = memory_read | memory_write;
    live_err  = !in_range(address) || (!mem_byte && (address[1:0] != 2'b00))
                || (memory_read && memory_write);
    accept    = (state == ST_IDLE) && !load_en && live_req;
    commit    = (accept && (WAIT_STATES == 0))
                || ((state == ST_ACCESS) && (wait_cnt == WAIT_LAST));

    op_addr   = (state == ST_IDLE) ? address      : req_addr;
    op_data   = (state == ST_IDLE) ? data_in      : req_data;
    op_byte   = (state == ST_IDLE) ? mem_byte     : req_byte;
    op_read   = (state == ST_IDLE) ? memory_read  : req_read;
    op_write  = (state == ST_IDLE) ? memory_write : req_write;
    op_err    = (state == ST_IDLE) ? live_err     : req_err;
    op_off    = op_addr - BASE_ADDR;
    load_off  = load_addr - BASE_ADDR;

    ram_we    = 4'h0;
    ram_addr  = AW'(op_off >> 2);
    ram_wdata = lane_merge(op_byte, op_data);

    if ((state == ST_IDLE) && load_en) begin
      ram_addr  = AW'(load_off >> 2);
      ram_wdata = load_data;
      if (in_range(load_addr)) ram_we = 4'hF;
    end else if (commit && op_write && !op_err) begin
      ram_we = lane_be(op_byte, op_addr[1:0]);
    end

    if (op_err)       rd_val = 32'h0;
    else if (op_byte) rd_val = {24'h0, lane_select(ram_rdata, op_addr[1:0])};
    else              rd_val = ram_rdata;
  end

  // FSM, request latch and registered response.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      data_out  <= 32'h0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      req_addr  <= 32'h0;
      req_data  <= 32'h0;
      req_byte  <= 1'b0;
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;

      if (accept) begin
        req_addr  <= address;
        req_data  <= data_in;
        req_byte  <= mem_byte;
        req_read  <= memory_read;
        req_write <= memory_write;
        req_err   <= live_err;
        wait_cnt  <= '0;
      end

      if (commit) begin
        state     <= ST_RESP;
        mem_ready <= 1'b1;
        mem_error <= op_err;
        if (op_read) data_out <= rd_val;
      end else begin
        unique case (state)
          ST_IDLE:   if (accept) state <= ST_ACCESS;
          ST_ACCESS: wait_cnt <= wait_cnt + WAIT_W'(1);
          ST_RESP:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states, the last
// one at a non-zero base) checked against an array model of memory contents.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic [31:0] address   [NDUT];
  logic [31:0] data_in   [NDUT];
  logic [31:0] data_out  [NDUT];
  logic [31:0] load_addr [NDUT];
  logic [31:0] load_data [NDUT];
  logic        memory_read  [NDUT];
  logic        memory_write [NDUT];
  logic        mem_byte     [NDUT];
  logic        load_en      [NDUT];
  logic        mem_ready    [NDUT];
  logic        mem_error    [NDUT];

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .n_reset(n_reset), .address(address[0]), .data_in(data_in[0]),
    .data_out(data_out[0]), .memory_read(memory_read[0]), .memory_write(memory_write[0]),
    .mem_byte(mem_byte[0]), .mem_ready(mem_ready[0]), .mem_error(mem_error[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .n_reset(n_reset), .address(address[1]), .data_in(data_in[1]),
    .data_out(data_out[1]), .memory_read(memory_read[1]), .memory_write(memory_write[1]),
    .mem_byte(mem_byte[1]), .mem_ready(mem_ready[1]), .mem_error(mem_error[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .n_reset(n_reset), .address(address[2]), .data_in(data_in[2]),
    .data_out(data_out[2]), .memory_read(memory_read[2]), .memory_write(memory_write[2]),
    .mem_byte(mem_byte[2]), .mem_ready(mem_ready[2]), .mem_error(mem_error[2]),
    .load_en(load_en[2]), .load_addr(load_addr[2]), .load_data(load_data[2]));

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [NDUT][DEPTH];
  logic [31:0] exp_dout [NDUT];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000 : 32'h0;
  endfunction

  function automatic logic in_rng(input int d, input logic [31:0] a);
    return (a >= base_of(d)) && ((a - base_of(d)) < 32'(4 * DEPTH));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Preload one word; called on a negedge while the instance is idle.
  task automatic preload(input int d, input logic [31:0] a, input logic [31:0] dat);
    load_en[d] = 1'b1; load_addr[d] = a; load_data[d] = dat;
    @(negedge clk);
    load_en[d] = 1'b0;
    if (in_rng(d, a)) mdl[d][(a - base_of(d)) >> 2] = dat;
  endtask

  // One core access: updates the model, drives the request, waits for the
  // ready pulse and checks latency, error flag, read data and pulse width.
  task automatic access(input int d, input logic rd, input logic wr, input logic byt,
                        input logic [31:0] a, input logic [31:0] dat, input string tag);
    logic err;
    int   idx, lane, cyc;
    err  = !in_rng(d, a) || (!byt && (a[1:0] != 2'b00)) || (rd && wr);
    lane = int'(a[1:0]);
    idx  = err ? 0 : int'((a - base_of(d)) >> 2);
    if (rd) begin
      if (err)      exp_dout[d] = 32'h0;
      else if (byt) exp_dout[d] = (mdl[d][idx] >> (8 * lane)) & 32'hFF;
      else          exp_dout[d] = mdl[d][idx];
    end
    if (wr && !err) begin
      if (byt) mdl[d][idx] = (mdl[d][idx] & ~(32'hFF << (8 * lane)))
                             | ({24'h0, dat[7:0]} << (8 * lane));
      else     mdl[d][idx] = dat;
    end
    address[d] = a; data_in[d] = dat; mem_byte[d] = byt;
    memory_read[d] = rd; memory_write[d] = wr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_ready[d] && cyc < 20);
    check({tag, ".lat"}, 32'(cyc), 32'(ws_of(d) + 1));
    check({tag, ".err"}, 32'(mem_error[d]), 32'(err));
    check({tag, ".dout"}, data_out[d], exp_dout[d]);
    memory_read[d] = 1'b0; memory_write[d] = 1'b0;
    @(negedge clk);
    check({tag, ".pulse"}, 32'(mem_ready[d]), 32'h0);
  endtask

  initial begin
    int pulses;
    n_reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      address[d] = '0; data_in[d] = '0; load_addr[d] = '0; load_data[d] = '0;
      memory_read[d] = 1'b0; memory_write[d] = 1'b0; mem_byte[d] = 1'b0;
      load_en[d] = 1'b0; exp_dout[d] = '0;
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst%0d.dout", d), data_out[d], 32'h0);
      check($sformatf("rst%0d.rdy", d), 32'(mem_ready[d]), 32'h0);
      check($sformatf("rst%0d.err", d), 32'(mem_error[d]), 32'h0);
    end
    n_reset = 1'b1;
    @(negedge clk);

    // Preload then word read, one wait state.
    preload(1, 32'h100, 32'hE3A01005);
    access(1, 1, 0, 0, 32'h100, 32'h0, "t1.rd");

    // Word write, byte merges, word and byte read-back.
    access(1, 0, 1, 0, 32'h200, 32'h11223344, "t2.ww");
    access(1, 0, 1, 1, 32'h201, 32'h000000AA, "t2.bw1");
    access(1, 0, 1, 1, 32'h203, 32'hFFFFFFAA, "t2.bw3");
    access(1, 1, 0, 0, 32'h200, 32'h0, "t2.rw");
    check("t2.val", data_out[1], 32'hAA22AA44);
    access(1, 1, 0, 1, 32'h202, 32'h0, "t2.rb");
    check("t2.bval", data_out[1], 32'h00000022);

    // Misaligned word, past-the-end write (no aliasing), edge addresses.
    preload(1, 32'h0, 32'h0BADF00D);
    access(1, 1, 0, 0, 32'h102, 32'h0, "t3.mis");
    access(1, 0, 1, 0, 32'(4 * DEPTH), 32'h12345678, "t3.oob");
    access(1, 1, 0, 0, 32'h0, 32'h0, "t3.w0");
    preload(1, 32'(4 * DEPTH - 4), 32'hCAFE0123);
    access(1, 1, 0, 1, 32'(4 * DEPTH - 1), 32'h0, "t3.last");
    preload(0, 32'(4 * DEPTH), 32'hFFFFFFFF);
    preload(0, 32'h0, 32'h00C0FFEE);
    access(0, 1, 0, 0, 32'h0, 32'h0, "t3.ldoob");
    access(2, 1, 0, 0, 32'h0FFC, 32'h0, "t3.below");

    // Read and write together.
    access(1, 1, 1, 0, 32'h200, 32'h99999999, "t4.both");
    access(1, 1, 0, 0, 32'h200, 32'h0, "t4.keep");

    // Reset during ACCESS of a write.
    preload(1, 32'h300, 32'h13579BDF);
    access(1, 1, 0, 0, 32'h100, 32'h0, "t5.pre");
    address[1] = 32'h300; data_in[1] = 32'hDEADBEEF; mem_byte[1] = 1'b0;
    memory_write[1] = 1'b1;
    @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("t5.dout", data_out[1], 32'h0);
    check("t5.rdy", 32'(mem_ready[1]), 32'h0);
    check("t5.err", 32'(mem_error[1]), 32'h0);
    memory_write[1] = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    for (int d = 0; d < NDUT; d++) exp_dout[d] = 32'h0;
    @(negedge clk);
    access(1, 1, 0, 0, 32'h300, 32'h0, "t5.after");

    // Latency at 0 and 3 wait states; load beats a simultaneous request.
    preload(2, 32'h1010, 32'h31415926);
    access(2, 1, 0, 0, 32'h1010, 32'h0, "t6.w3");
    access(0, 0, 1, 0, 32'h104, 32'h27182818, "t6.w0");
    load_en[0] = 1'b1; load_addr[0] = 32'h108; load_data[0] = 32'h5A5A1234;
    address[0] = 32'h108; memory_read[0] = 1'b1; mem_byte[0] = 1'b0;
    @(negedge clk);
    check("t6.ldwin", 32'(mem_ready[0]), 32'h0);
    load_en[0] = 1'b0;
    mdl[0][32'h108 >> 2] = 32'h5A5A1234;
    access(0, 1, 0, 0, 32'h108, 32'h0, "t6.ldnext");

    // Held read: one ready pulse per access.
    address[1] = 32'h100; mem_byte[1] = 1'b0; memory_read[1] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready[1]) pulses++;
    end
    memory_read[1] = 1'b0;
    @(negedge clk);
    check("t6.held", 32'(pulses), 32'h2);
    exp_dout[1] = 32'hE3A01005;
    check("t6.hdout", data_out[1], exp_dout[1]);

    // Randomized traffic against the model.
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 16; i++) preload(d, base_of(d) + 32'h400 + 32'(4 * i), $urandom);
    for (int n = 0; n < 60; n++) begin
      int d, sel;
      logic rd, wr, byt;
      logic [31:0] a;
      d   = $urandom_range(0, 2);
      sel = $urandom_range(0, 15);
      byt = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      wr  = !rd || (sel == 0);
      a   = base_of(d) + 32'h400 + 32'(4 * $urandom_range(0, 15));
      if (byt || sel == 1) a = a + 32'($urandom_range(0, 3));
      if (sel == 2) a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      access(d, rd, wr, byt, a, $urandom, $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 16; i++)
      access(1, 1, 0, 0, 32'h400 + 32'(4 * i), 32'h0, $sformatf("fin%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
